// File: rtl/inst_buffer.sv
// Circular instruction buffer between fetch and dispatch.
// Free space and dispatch outputs come from registered state only.
module inst_buffer #(
  parameter int N               = 3,
  parameter int DEPTH           = 8,
  parameter int PKT_W           = 32,
  parameter int NUM_SCALAR_BITS = $clog2(N + 1),
  parameter int CNT_BITS        = $clog2(DEPTH + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N-1:0][PKT_W-1:0]       inst_buffer_inputs,
  input  logic [NUM_SCALAR_BITS-1:0]    inst_valid,
  output logic [NUM_SCALAR_BITS-1:0]    inst_buffer_spots,
  input  logic                          restore_valid,
  output logic [N-1:0][PKT_W-1:0]       dispatch_packets,
  output logic [NUM_SCALAR_BITS-1:0]    dispatch_valid,
  input  logic [NUM_SCALAR_BITS-1:0]    dispatch_count,
  output logic [CNT_BITS-1:0]           occupancy
);

  localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SUM_W    = CNT_BITS + 1;
  localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(DEPTH);
  localparam logic [CNT_BITS-1:0] N_C     = CNT_BITS'(N);

  logic [PKT_W-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] head, tail;
  logic [CNT_BITS-1:0] count;

  logic [CNT_BITS-1:0] free, spots_c, dv_c, iv_c, dc_c, wr, rd;

  // Pointer plus increment (< 2*DEPTH) needs one compare-and-subtract, valid for any DEPTH.
  function automatic logic [PTR_BITS-1:0] wrap_add(input logic [PTR_BITS-1:0] ptr,
                                                   input logic [CNT_BITS-1:0] inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(ptr) + SUM_W'(inc);
    if (sum >= SUM_W'(DEPTH)) sum = sum - SUM_W'(DEPTH);
    return PTR_BITS'(sum);
  endfunction

  always_comb begin
    free    = DEPTH_C - count;
    spots_c = (free >= N_C) ? N_C : free;
    dv_c    = (count >= N_C) ? N_C : count;
    iv_c    = CNT_BITS'(inst_valid);
    dc_c    = CNT_BITS'(dispatch_count);
    wr      = (iv_c > spots_c) ? spots_c : iv_c;
    rd      = (dc_c > dv_c) ? dv_c : dc_c;
  end

  assign inst_buffer_spots = NUM_SCALAR_BITS'(spots_c);
  assign dispatch_valid    = NUM_SCALAR_BITS'(dv_c);
  assign occupancy         = count;

  always_comb begin
    dispatch_packets = '0;
    for (int i = 0; i < N; i++) begin
      if (CNT_BITS'(i) < dv_c)
        dispatch_packets[i] = mem[wrap_add(head, CNT_BITS'(i))];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (restore_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= wrap_add(head, rd);
      tail  <= wrap_add(tail, wr);
      count <= count + wr - rd;
    end
  end

  // Storage has no reset; unread slots are masked on the dispatch side.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (!restore_valid && (CNT_BITS'(i) < wr))
        mem[wrap_add(tail, CNT_BITS'(i))] <= inst_buffer_inputs[i];
    end
  end

  always @(posedge clock) begin
    if (!reset && !restore_valid) begin
      assert (inst_valid <= inst_buffer_spots)
        else $warning("inst_valid exceeds inst_buffer_spots; write clipped");
      assert (dispatch_count <= dispatch_valid)
        else $warning("dispatch_count exceeds dispatch_valid; read clipped");
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Testbench for inst_buffer (N=3, DEPTH=8) using a queue-based reference model.
module tb_inst_buffer;

  localparam int N        = 3;
  localparam int DEPTH    = 8;
  localparam int PKT_W    = 32;
  localparam int NSB      = 2;
  localparam int CNT_BITS = 4;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [N-1:0][PKT_W-1:0] inst_buffer_inputs;
  logic [NSB-1:0]          inst_valid;
  logic [NSB-1:0]          inst_buffer_spots;
  logic                    restore_valid;
  logic [N-1:0][PKT_W-1:0] dispatch_packets;
  logic [NSB-1:0]          dispatch_valid;
  logic [NSB-1:0]          dispatch_count;
  logic [CNT_BITS-1:0]     occupancy;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] model_q[$];
  logic [31:0] next_pc;
  logic [31:0] saved_pc;

  typedef struct {
    int iv;
    int dc;
    int occ;
    int spots;
    int dv;
    logic [31:0] pc0;
  } vec_t;
  vec_t vecs[9];

  inst_buffer #(.N(N), .DEPTH(DEPTH), .PKT_W(PKT_W)) dut (
    .clock(clock),
    .reset(reset),
    .inst_buffer_inputs(inst_buffer_inputs),
    .inst_valid(inst_valid),
    .inst_buffer_spots(inst_buffer_spots),
    .restore_valid(restore_valid),
    .dispatch_packets(dispatch_packets),
    .dispatch_valid(dispatch_valid),
    .dispatch_count(dispatch_count),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  function automatic int model_spots();
    int free;
    free = DEPTH - model_q.size();
    return (free >= N) ? N : free;
  endfunction

  function automatic int model_dv();
    return (model_q.size() >= N) ? N : model_q.size();
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkModel(input string tag);
    int dv;
    dv = model_dv();
    checkOutput({tag, " occupancy"}, int'(occupancy), model_q.size());
    checkOutput({tag, " spots"}, int'(inst_buffer_spots), model_spots());
    checkOutput({tag, " dispatch_valid"}, int'(dispatch_valid), dv);
    for (int i = 0; i < N; i++)
      checkOutput($sformatf("%s pkt%0d", tag, i), int'(dispatch_packets[i]),
                  (i < dv) ? int'(model_q[i]) : 0);
  endtask

  // Drive one cycle, check pre-edge outputs against the model, then advance the model.
  task automatic applyStimulus(input int iv, input int dc, input bit rv,
                               input bit rand_pkts, input string tag);
    int wr, rd;
    inst_valid     = NSB'(iv);
    dispatch_count = NSB'(dc);
    restore_valid  = rv;
    for (int i = 0; i < N; i++)
      inst_buffer_inputs[i] = rand_pkts ? $urandom : next_pc + 32'(4 * i);
    checkModel(tag);
    wr = (iv < model_spots()) ? iv : model_spots();
    rd = (dc < model_dv()) ? dc : model_dv();
    @(posedge clock);
    if (rv) begin
      model_q.delete();
    end else begin
      repeat (rd) void'(model_q.pop_front());
      for (int i = 0; i < wr; i++) model_q.push_back(inst_buffer_inputs[i]);
      if (!rand_pkts) next_pc = next_pc + 32'(4 * wr);
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset              = 1'b1;
    inst_valid         = '0;
    dispatch_count     = '0;
    restore_valid      = 1'b0;
    inst_buffer_inputs = '0;
    next_pc            = 32'h0;

    vecs[0] = '{3, 0, 0, 3, 0, 32'h00};
    vecs[1] = '{3, 0, 3, 3, 3, 32'h00};
    vecs[2] = '{3, 0, 6, 2, 3, 32'h00};
    vecs[3] = '{3, 3, 8, 0, 3, 32'h00};
    vecs[4] = '{0, 2, 5, 3, 3, 32'h0C};
    vecs[5] = '{3, 3, 3, 3, 3, 32'h14};
    vecs[6] = '{3, 3, 3, 3, 3, 32'h20};
    vecs[7] = '{3, 3, 3, 3, 3, 32'h2C};
    vecs[8] = '{0, 0, 3, 3, 3, 32'h38};

    #12;
    checkOutput("reset occupancy", int'(occupancy), 0);
    checkOutput("reset spots", int'(inst_buffer_spots), 3);
    checkOutput("reset dispatch_valid", int'(dispatch_valid), 0);
    checkOutput("reset packets", int'(dispatch_packets), 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Fill, full-with-drain and steady streaming across the wrap point.
    for (int k = 0; k < 9; k++) begin
      checkOutput($sformatf("vec%0d occupancy", k), int'(occupancy), vecs[k].occ);
      checkOutput($sformatf("vec%0d spots", k), int'(inst_buffer_spots), vecs[k].spots);
      checkOutput($sformatf("vec%0d dispatch_valid", k), int'(dispatch_valid), vecs[k].dv);
      checkOutput($sformatf("vec%0d pkt0", k), int'(dispatch_packets[0]), int'(vecs[k].pc0));
      applyStimulus(vecs[k].iv, vecs[k].dc, 1'b0, 1'b0, $sformatf("vec%0d", k));
    end

    // Restore with same-cycle writes and reads pending.
    applyStimulus(3, 0, 1'b0, 1'b0, "pre-restore");
    checkOutput("pre-restore occupancy", int'(occupancy), 6);
    applyStimulus(3, 2, 1'b1, 1'b0, "restore");
    checkOutput("post-restore occupancy", int'(occupancy), 0);
    checkOutput("post-restore dispatch_valid", int'(dispatch_valid), 0);
    checkOutput("post-restore spots", int'(inst_buffer_spots), 3);
    saved_pc = next_pc;
    applyStimulus(1, 0, 1'b0, 1'b0, "after-restore write");
    checkOutput("after-restore pkt0", int'(dispatch_packets[0]), int'(saved_pc));

    // Over-asking dispatch is clipped to what is valid.
    applyStimulus(1, 0, 1'b0, 1'b0, "partial setup");
    checkOutput("partial setup occupancy", int'(occupancy), 2);
    saved_pc = next_pc;
    applyStimulus(1, 3, 1'b0, 1'b0, "clipped dispatch");
    checkOutput("clipped occupancy", int'(occupancy), 1);
    checkOutput("clipped pkt0", int'(dispatch_packets[0]), int'(saved_pc));
    saved_pc = next_pc;
    applyStimulus(1, 1, 1'b0, 1'b0, "single in/out");
    checkOutput("single in/out occupancy", int'(occupancy), 1);
    checkOutput("single in/out pkt0", int'(dispatch_packets[0]), int'(saved_pc));

    // Asynchronous reset in the middle of a cycle with five entries held.
    applyStimulus(3, 0, 1'b0, 1'b0, "midreset fill a");
    applyStimulus(1, 0, 1'b0, 1'b0, "midreset fill b");
    checkOutput("midreset pre occupancy", int'(occupancy), 5);
    inst_valid     = '0;
    dispatch_count = '0;
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset occupancy", int'(occupancy), 0);
    checkOutput("midreset dispatch_valid", int'(dispatch_valid), 0);
    checkOutput("midreset spots", int'(inst_buffer_spots), 3);
    checkOutput("midreset packets", int'(dispatch_packets), 0);
    model_q.delete();
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
    saved_pc = next_pc;
    applyStimulus(1, 0, 1'b0, 1'b0, "post-reset write");
    checkOutput("post-reset pkt0", int'(dispatch_packets[0]), int'(saved_pc));
    checkOutput("post-reset occupancy", int'(occupancy), 1);

    // Randomized protocol-legal traffic with occasional restores.
    for (int k = 0; k < 400; k++) begin
      applyStimulus($urandom_range(model_spots(), 0), $urandom_range(model_dv(), 0),
                    ($urandom_range(15, 0) == 0), 1'b1, $sformatf("rand%0d", k));
    end
    inst_valid     = '0;
    dispatch_count = '0;
    restore_valid  = 1'b0;
    checkModel("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
